sim_ram_line_arbiter: RTL

- Arbitrates cache-line read/write requests from NREQ requesters (e.g. ifetch, dcache) onto the single-port 64-bit simulation RAM helper.
- Converts each accepted line request into BEATS sequential word accesses.
- Assembles read beats using the helper's 1-cycle registered read latency.
- Returns one response per request; sits between the cache refill/writeback logic and the RAM helper in the sim top.

---
 rtl/sim_ram_pkg.sv | 27 ++
 rtl/sim_ram_line_arbiter_rr_arbiter.sv | 27 ++
 rtl/sim_ram_line_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sim_ram_pkg.sv
// Shared state encoding, word geometry and strobe expansion for the
// simulation RAM line arbiter.
package sim_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR_ISSUE,
        RESP
    } state_t;

    localparam int WORD_BYTES    = 8;
    localparam int WORD_OFF_W    = $clog2(WORD_BYTES);
    localparam int DEFAULT_BEATS = 8;

    // Each strobe bit enables one whole byte lane of the 64-bit word.
    function automatic logic [63:0] strb_to_mask(input logic [WORD_BYTES-1:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int j = 0; j < WORD_BYTES; j++) begin
            mask[8*j +: 8] = {8{strb[j]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sim_ram_line_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter: the search for a winner starts at ptr and
// wraps, producing a one-hot grant plus the winner's index.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NREQ]) begin
                any    = 1'b1;
                winner = IDX_W'((int'(ptr) + i) % NREQ);
                grant[(int'(ptr) + i) % NREQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_ram_line_arbiter.sv
// Serialises cache-line read/write requests from several requesters onto the
// single-port 64-bit simulation RAM helper, one word per cycle.
module sim_ram_line_arbiter
    import sim_ram_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int BEATS  = DEFAULT_BEATS,
    parameter int LINE_W = BEATS * 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*64-1:0]         req_addr,
    input  logic [NREQ*LINE_W-1:0]     req_wdata,
    input  logic [NREQ*BEATS*8-1:0]    req_wstrb,
    output logic [NREQ-1:0]            resp_valid,
    output logic [LINE_W-1:0]          resp_rdata,
    output logic                       ram_enable,
    output logic                       ram_r_enable,
    output logic [63:0]                ram_r_index,
    input  logic [63:0]                ram_r_data,
    output logic                       ram_w_enable,
    output logic [63:0]                ram_w_index,
    output logic [63:0]                ram_w_data,
    output logic [63:0]                ram_w_mask
);

    localparam int IDX_W      = $clog2(NREQ);
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int LINE_OFF_W = WORD_OFF_W + BEAT_W;
    localparam int STRB_W     = BEATS * WORD_BYTES;

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    winner;
    logic [NREQ-1:0]     grant;
    logic                any_req;
    logic                is_write;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   prev_beat;
    logic                last_beat;
    logic [63:0]         base_index;
    logic [63:0]         beat_index;
    logic [LINE_W-1:0]   wdata_buf;
    logic [STRB_W-1:0]   wstrb_buf;
    logic [LINE_W-1:0]   line_buf;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any_req)
    );

    assign prev_beat  = beat - BEAT_W'(1);
    assign last_beat  = (beat == BEAT_W'(BEATS - 1));
    assign beat_index = base_index | 64'(beat);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (any_req) next_state = req_write[winner] ? WR_ISSUE : RD_ISSUE;
            RD_ISSUE: if (last_beat) next_state = RD_DRAIN;
            RD_DRAIN: next_state = RESP;
            WR_ISSUE: if (last_beat) next_state = RESP;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Read data lags its index by one cycle, so each issue cycle stores the
    // previous beat and the drain cycle stores the final one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            is_write   <= 1'b0;
            beat       <= '0;
            base_index <= '0;
            wdata_buf  <= '0;
            wstrb_buf  <= '0;
            line_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= winner;
                        rr_ptr     <= (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
                        is_write   <= req_write[winner];
                        base_index <= {{WORD_OFF_W{1'b0}},
                                       req_addr[64*winner + LINE_OFF_W +: 64 - LINE_OFF_W],
                                       {BEAT_W{1'b0}}};
                        wdata_buf  <= req_wdata[LINE_W*winner +: LINE_W];
                        wstrb_buf  <= req_wstrb[STRB_W*winner +: STRB_W];
                        beat       <= '0;
                    end
                end
                RD_ISSUE: begin
                    if (beat != '0) begin
                        line_buf[64*prev_beat +: 64] <= ram_r_data;
                    end
                    beat <= beat + 1'b1;
                end
                RD_DRAIN: line_buf[LINE_W-64 +: 64] <= ram_r_data;
                WR_ISSUE: beat <= beat + 1'b1;
                default: ;
            endcase
        end
    end

    // Ready is masked by reset so nothing is handshaken while reset is held.
    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        resp_rdata   = '0;
        ram_enable   = 1'b0;
        ram_r_enable = 1'b0;
        ram_r_index  = '0;
        ram_w_enable = 1'b0;
        ram_w_index  = '0;
        ram_w_data   = '0;
        ram_w_mask   = '0;
        case (state)
            IDLE: req_ready = grant & {NREQ{~reset}};
            RD_ISSUE: begin
                ram_enable   = 1'b1;
                ram_r_enable = 1'b1;
                ram_r_index  = beat_index;
            end
            WR_ISSUE: begin
                ram_enable   = 1'b1;
                ram_w_enable = 1'b1;
                ram_w_index  = beat_index;
                ram_w_data   = wdata_buf[64*beat +: 64];
                ram_w_mask   = strb_to_mask(wstrb_buf[WORD_BYTES*beat +: WORD_BYTES]);
            end
            RESP: begin
                resp_valid[owner] = 1'b1;
                resp_rdata        = is_write ? '0 : line_buf;
            end
            default: ;
        endcase
    end

endmodule
